// File: rtl/ps_kernel_feeder_if.sv
// Source stream and kernel-control write-port signals for ps_kernel_feeder.
// PS_KERNEL_FEEDER_SOF_EN adds i_sof / o_sync_err.
interface ps_kernel_feeder_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_req;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_frame_done;
`ifdef PS_KERNEL_FEEDER_SOF_EN
  logic                  i_sof;
  logic                  o_sync_err;

  modport slave (
    input  i_data, i_valid, i_req, i_sof,
    output o_ready, o_data, o_valid, o_frame_done, o_sync_err
  );
  modport master (
    output i_data, i_valid, i_req, i_sof,
    input  o_ready, o_data, o_valid, o_frame_done, o_sync_err
  );
`else
  modport slave (
    input  i_data, i_valid, i_req,
    output o_ready, o_data, o_valid, o_frame_done
  );
  modport master (
    output i_data, i_valid, i_req,
    input  o_ready, o_data, o_valid, o_frame_done
  );
`endif
endinterface

// File: rtl/ps_kernel_feeder.sv
// Pulls pixels from a ready/valid source and emits one full image row per i_req grant.
// Optional frame synchronisation on i_sof is enabled by PS_KERNEL_FEEDER_SOF_EN.
module ps_kernel_feeder #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 1,
  parameter int HOLDOFF     = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  ps_kernel_feeder_if.slave bus
);
  localparam int PIX_W  = $clog2(LINE_LENGTH) + 1;
  localparam int LINE_W = $clog2(LINE_COUNT) + 1;
  localparam int HOLD_W = $clog2(HOLDOFF) + 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_LENGTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, HOLD = 2'd2} state_e;

  state_e                state_q, state_d, cur_state;
  logic [PIX_W-1:0]      pix_q, pix_d, cur_pix;
  logic [LINE_W-1:0]     line_q, line_d, cur_line;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  ready, xfer, fwd, sof_take, synced;

  assign xfer = bus.i_valid & ready;

`ifdef PS_KERNEL_FEEDER_SOF_EN
  logic synced_q, synced_d;
  logic err_q, err_d;

  // Until the first SOF arrives the source is drained and its pixels dropped.
  assign synced   = synced_q;
  assign ready    = !synced_q || (state_q == BURST);
  assign sof_take = xfer && !synced_q && bus.i_sof;
  assign fwd      = xfer && (synced_q || bus.i_sof);
  assign synced_d = synced_q | sof_take;
  assign err_d    = synced_q && xfer &&
                    (bus.i_sof ? ((pix_q != '0) || (line_q != '0))
                               : ((pix_q == '0) && (line_q == '0)));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      synced_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      synced_q <= synced_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_sync_err = err_q;
`else
  assign synced   = 1'b1;
  assign ready    = (state_q == BURST);
  assign sof_take = 1'b0;
  assign fwd      = xfer;
`endif

  always_comb begin
    // An accepted SOF behaves like pixel 0 of line 0 arriving in BURST.
    cur_state = sof_take ? BURST : state_q;
    cur_pix   = sof_take ? '0 : pix_q;
    cur_line  = sof_take ? '0 : line_q;
    state_d   = cur_state;
    pix_d     = cur_pix;
    line_d    = cur_line;
    hold_d    = hold_q;
    data_d    = fwd ? bus.i_data : data_q;
    valid_d   = fwd;
    done_d    = 1'b0;
    if (synced || sof_take) begin
      case (cur_state)
        IDLE: begin
          if (bus.i_req) state_d = BURST;
        end
        BURST: begin
          if (fwd) begin
            if (cur_pix == PIX_LAST) begin
              pix_d   = '0;
              line_d  = (cur_line == LINE_LAST) ? '0 : cur_line + 1'b1;
              done_d  = (cur_line == LINE_LAST);
              hold_d  = '0;
              state_d = HOLD;
            end else begin
              pix_d = cur_pix + 1'b1;
            end
          end
        end
        HOLD: begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_ps_kernel_feeder.sv
// Scoreboard bench for ps_kernel_feeder (8x4 frame, HOLDOFF 2, 8-bit pixels).
// Builds with or without PS_KERNEL_FEEDER_SOF_EN.
module tb_ps_kernel_feeder;
  localparam int LL = 8;
  localparam int LC = 4;
  localparam int HO = 2;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ps_kernel_feeder_if #(.DATA_WIDTH(DW)) bus ();

  ps_kernel_feeder #(
    .LINE_LENGTH(LL),
    .LINE_COUNT (LC),
    .DATA_WIDTH (DW),
    .HOLDOFF    (HO)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcount   = 0;
  int   done_at  = -1;
  int   err_seen = 0;
  int   err_vidx = -1;
  int   exp_err  = 0;
  int   m_pix    = 0;
  int   m_line   = 0;
  bit   m_synced;
  bit   auto_sof = 1'b0;
  bit   last_ready;
  bit   last_xfer;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference model of the row/frame position, advanced on every observed transfer.
  task automatic model_xfer();
    bit sof = 1'b0;
`ifdef PS_KERNEL_FEEDER_SOF_EN
    sof = bus.i_sof;
    if (m_synced && (sof ? (m_pix != 0 || m_line != 0) : (m_pix == 0 && m_line == 0)))
      exp_err++;
`endif
    if (!m_synced && !sof) return;
    m_synced = 1'b1;
    exp_q.push_back(exp_t'{data: bus.i_data, done: (m_pix == LL-1 && m_line == LC-1)});
    m_pix++;
    if (m_pix == LL) begin
      m_pix  = 0;
      m_line = (m_line + 1) % LC;
    end
  endtask

  task automatic step();
`ifdef PS_KERNEL_FEEDER_SOF_EN
    if (auto_sof) bus.i_sof = (m_pix == 0 && m_line == 0);
`endif
    @(negedge clk);
    last_ready = bus.o_ready;
    last_xfer  = bus.i_valid & bus.o_ready;
    if (last_xfer) model_xfer();
    @(posedge clk);
    #1;
    if (last_xfer) bus.i_data = bus.i_data + 1'b1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    exp_q.delete();
    m_pix  = 0;
    m_line = 0;
`ifdef PS_KERNEL_FEEDER_SOF_EN
    m_synced = 1'b0;
`else
    m_synced = 1'b1;
`endif
  endtask

  always @(negedge clk) begin
    if (rstn) begin
`ifdef PS_KERNEL_FEEDER_SOF_EN
      if (bus.o_sync_err) begin
        err_seen++;
        err_vidx = vcount;
        $display("[%0t] sync_err at pix %0d", $time, vcount);
      end
`endif
      check("frame_done_without_valid", int'(bus.o_frame_done & ~bus.o_valid), 0);
      if (bus.o_valid) begin
        check("sb_has_entry", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("o_data", int'(bus.o_data), int'(mon_e.data));
          check("o_frame_done", int'(bus.o_frame_done), int'(mon_e.done));
        end
        $display("[%0t] out pix %0d data %02h frame_done %0b",
                 $time, vcount, bus.o_data, bus.o_frame_done);
        if (bus.o_frame_done) done_at = vcount;
        vcount++;
      end
    end
  end

  initial begin
    int cnt;
    int vbase;
    bus.i_data  = '0;
    bus.i_valid = 1'b0;
    bus.i_req   = 1'b0;
`ifdef PS_KERNEL_FEEDER_SOF_EN
    bus.i_sof   = 1'b0;
`endif
    apply_reset();
    #12;
    check("rst_o_valid", int'(bus.o_valid), 0);
    check("rst_o_ready", int'(bus.o_ready), 0);
    check("rst_o_data", int'(bus.o_data), 0);
    check("rst_o_frame_done", int'(bus.o_frame_done), 0);
`ifdef PS_KERNEL_FEEDER_SOF_EN
    check("rst_o_sync_err", int'(bus.o_sync_err), 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

`ifdef PS_KERNEL_FEEDER_SOF_EN
    // Three junk pixels, the SOF pixel, then a stray SOF on pixel 4.
    bus.i_req   = 1'b1;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.i_data = DW'(8'hA1 + k);
      step();
      if (k == 0) check("unsynced_ready", int'(last_ready), 1);
    end
    for (int k = 0; k < 8; k++) begin
      bus.i_data = DW'(k);
      bus.i_sof  = (k == 0 || k == 4);
      step();
    end
    auto_sof = 1'b1;
    for (int c = 0; c < 40; c++) step();
    check("sof_frame_done_pix", done_at, 31);
    check("sync_err_count", err_seen, 1);
    check("sync_err_at_pix", err_vidx, 4);
    check("sync_err_model", err_seen, exp_err);
`else
    // i_req low: no ready, no output.
    bus.i_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      cnt += int'(last_ready);
    end
    check("idle_no_ready", cnt, 0);
    check("idle_no_valid", vcount, 0);

    // i_req held high: IDLE, 8 ready, HOLD x2, IDLE, ...
    bus.i_req = 1'b1;
    for (int c = 0; c < 45; c++) begin
      step();
      check("ready_pattern", int'(last_ready), int'(c != 0 && ((c - 1) % 11) < 8));
    end
    check("frame_done_pix", done_at, 31);

    // i_req drops after the 3rd pixel; the row still completes.
    vbase = vcount;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      cnt += int'(last_xfer);
    end
    check("req_drop_first", cnt, 3);
    bus.i_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      cnt += int'(last_ready);
    end
    check("req_drop_rest", cnt, 5);
    check("req_drop_pixels", vcount - vbase, 8);

    // Source valid toggling 1010.. stretches the row to 15 cycles.
    bus.i_valid = 1'b0;
    bus.i_req   = 1'b1;
    step();
    vbase = vcount;
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      bus.i_valid = (k % 2 == 0);
      step();
      cnt += int'(last_ready);
      if (k == 0) bus.i_req = 1'b0;
    end
    check("toggle_burst_cycles", cnt, 15);
    check("toggle_pixels", vcount - vbase, 8);

    // Asynchronous reset after the 5th pixel of a row.
    bus.i_valid = 1'b1;
    bus.i_req   = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12 && cnt < 5; k++) begin
      step();
      cnt += int'(last_xfer);
    end
    check("pre_reset_pixels", cnt, 5);
    @(negedge clk);
    #2;
    apply_reset();
    #1;
    check("midrst_o_valid", int'(bus.o_valid), 0);
    check("midrst_o_ready", int'(bus.o_ready), 0);
    check("midrst_o_data", int'(bus.o_data), 0);
    check("midrst_o_frame_done", int'(bus.o_frame_done), 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(bus.o_valid) + int'(bus.o_ready);
    end
    check("in_reset_quiet", cnt, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    vbase   = vcount;
    done_at = -1;
    for (int c = 0; c < 45; c++) step();
    check("post_reset_frame_done", done_at - vbase, 31);
`endif

    bus.i_req   = 1'b0;
    bus.i_valid = 1'b0;
    repeat (4) step();
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
